// File: rtl/ball_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ball_track_ctrl
//  Description : Frame-synchronous ball tracking controller. It waits for
//                sensor settling frames after START. It then enables the ball
//                detector and evaluates each per-frame detector result
//                against a minimum pixel count. Accepted positions go to a
//                valid/ready consumer. Consecutive misses are counted and
//                raise a LOST flag.
//  Ports       : CLK, RST_N (async, active-low)
//                START            - tracking request level
//                VGA_VS           - active-low vertical sync (fall = frame)
//                RES_VALID/X/Y/COUNT - detector end-of-frame result
//                DET_ENABLE       - detector enable (DETECT/EVAL only)
//                POS_X/POS_Y/POS_VALID/POS_READY - accepted position output
//                LOST             - ball-lost flag
//                OVERRUN          - pulse when a pending position is replaced
//                FRAME_CNT        - frames seen while not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_track_ctrl #(
    parameter int unsigned MIN_COUNT   = 8,
    parameter int unsigned LOST_FRAMES = 4,
    parameter int unsigned SKIP_FRAMES = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        VGA_VS,
    input  logic        RES_VALID,
    input  logic [5:0]  RES_X,
    input  logic [4:0]  RES_Y,
    input  logic [7:0]  RES_COUNT,
    output logic        DET_ENABLE,
    output logic [5:0]  POS_X,
    output logic [4:0]  POS_Y,
    output logic        POS_VALID,
    input  logic        POS_READY,
    output logic        LOST,
    output logic        OVERRUN,
    output logic [15:0] FRAME_CNT
);

    // Counter widths sized to hold their terminal value, never narrower than 1.
    localparam int unsigned MISS_W = (LOST_FRAMES < 1) ? 1 : $clog2(LOST_FRAMES + 1);
    localparam int unsigned SKIP_W = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

    localparam logic [MISS_W-1:0] C_LOST     = MISS_W'(LOST_FRAMES);
    localparam logic [MISS_W-1:0] C_MISS_ONE = MISS_W'(1);
    localparam logic [SKIP_W-1:0] C_SKIP     = SKIP_W'(SKIP_FRAMES);
    localparam logic [SKIP_W-1:0] C_SKIP_ONE = SKIP_W'(1);
    localparam logic [8:0]        C_MIN      = 9'(MIN_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        DETECT  = 2'd2,
        EVAL    = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_vs_d;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic [MISS_W-1:0] r_miss_cnt;
    logic [5:0]        r_lat_x;
    logic [4:0]        r_lat_y;
    logic [7:0]        r_lat_cnt;

    logic              w_fe;
    logic              w_hit;
    logic [MISS_W-1:0] w_miss_next;
    logic              w_miss_lost;

    // Frame edge: the previous sample was high and VGA_VS is now low.
    assign w_fe        = r_vs_d & ~VGA_VS;
    assign w_hit       = ({1'b0, r_lat_cnt} >= C_MIN);
    // Saturating miss increment; the compare guards the add, so it never wraps.
    assign w_miss_next = (r_miss_cnt < C_LOST) ? (r_miss_cnt + C_MISS_ONE) : C_LOST;
    assign w_miss_lost = (w_miss_next == C_LOST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_vs_d     <= 1'b1;   // high history so reset release gives no false edge
            r_skip_cnt <= '0;
            r_miss_cnt <= '0;
            r_lat_x    <= '0;
            r_lat_y    <= '0;
            r_lat_cnt  <= '0;
            DET_ENABLE <= 1'b0;
            POS_X      <= '0;
            POS_Y      <= '0;
            POS_VALID  <= 1'b0;
            LOST       <= 1'b0;
            OVERRUN    <= 1'b0;
            FRAME_CNT  <= '0;
        end else begin
            r_vs_d  <= VGA_VS;
            OVERRUN <= 1'b0;

            if (w_fe && (r_state != IDLE)) begin
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end

            // The handshake completes independently of the FSM, even when
            // tracking is stopped. A hit in EVAL below overrides this clear.
            if (POS_VALID && POS_READY) begin
                POS_VALID <= 1'b0;
            end

            if (!START) begin
                r_state    <= IDLE;
                r_skip_cnt <= '0;
                r_miss_cnt <= '0;
                LOST       <= 1'b0;
                DET_ENABLE <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= WAIT_VS;
                        r_skip_cnt <= '0;
                    end

                    WAIT_VS: begin
                        if (w_fe) begin
                            if (r_skip_cnt < C_SKIP) begin
                                r_skip_cnt <= r_skip_cnt + C_SKIP_ONE;
                            end else begin
                                r_state    <= DETECT;
                                DET_ENABLE <= 1'b1;
                            end
                        end
                    end

                    DETECT: begin
                        // A result wins over a coincident frame edge.
                        if (RES_VALID) begin
                            r_lat_x   <= RES_X;
                            r_lat_y   <= RES_Y;
                            r_lat_cnt <= RES_COUNT;
                            r_state   <= EVAL;
                        end else if (w_fe) begin
                            r_miss_cnt <= w_miss_next;
                            LOST       <= LOST | w_miss_lost;
                        end
                    end

                    EVAL: begin
                        r_state <= DETECT;
                        if (w_hit) begin
                            POS_X      <= r_lat_x;
                            POS_Y      <= r_lat_y;
                            POS_VALID  <= 1'b1;
                            r_miss_cnt <= '0;
                            LOST       <= 1'b0;
                            // Replacing a position the consumer has not taken.
                            if (POS_VALID && !POS_READY) begin
                                OVERRUN <= 1'b1;
                            end
                        end else begin
                            r_miss_cnt <= w_miss_next;
                            LOST       <= LOST | w_miss_lost;
                        end
                    end

                    default: begin
                        r_state    <= IDLE;
                        DET_ENABLE <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ball_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_track_ctrl
//  Description : Self-checking bench for ball_track_ctrl. Frames are driven
//                as events. A frame-level reference model predicts the
//                accepted positions (queued) and the LOST/FRAME_CNT/DET_ENABLE
//                state. A monitor pops positions on every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_track_ctrl;

    localparam int MIN_C  = 8;
    localparam int LOST_F = 4;
    localparam int SKIP_F = 1;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic        VGA_VS;
    logic        RES_VALID;
    logic [5:0]  RES_X;
    logic [4:0]  RES_Y;
    logic [7:0]  RES_COUNT;
    logic        DET_ENABLE;
    logic [5:0]  POS_X;
    logic [4:0]  POS_Y;
    logic        POS_VALID;
    logic        POS_READY;
    logic        LOST;
    logic        OVERRUN;
    logic [15:0] FRAME_CNT;

    ball_track_ctrl #(
        .MIN_COUNT   (MIN_C),
        .LOST_FRAMES (LOST_F),
        .SKIP_FRAMES (SKIP_F)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .VGA_VS     (VGA_VS),
        .RES_VALID  (RES_VALID),
        .RES_X      (RES_X),
        .RES_Y      (RES_Y),
        .RES_COUNT  (RES_COUNT),
        .DET_ENABLE (DET_ENABLE),
        .POS_X      (POS_X),
        .POS_Y      (POS_Y),
        .POS_VALID  (POS_VALID),
        .POS_READY  (POS_READY),
        .LOST       (LOST),
        .OVERRUN    (OVERRUN),
        .FRAME_CNT  (FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
    } pos_t;

    int   checks = 0;
    int   errors = 0;
    pos_t exp_q[$];

    // Reference model: 0 = stopped, 1 = settling, 2 = tracking
    int m_mode   = 0;
    int m_skip   = 0;
    int m_miss   = 0;
    int m_lost   = 0;
    int m_frames = 0;
    int exp_ovr  = 0;
    int ovr_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every accepted handshake must match the oldest expected position.
    always @(negedge CLK) begin
        if (RST_N && OVERRUN) ovr_seen++;
        if (RST_N && POS_VALID && POS_READY) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pos_valid", 1, 0);
            end else begin
                pos_t e;
                e = exp_q.pop_front();
                chk("pos_x", int'(POS_X), int'(e.x));
                chk("pos_y", int'(POS_Y), int'(e.y));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- model ----------------
    task automatic model_miss();
        if (m_miss < LOST_F) m_miss++;
        if (m_miss == LOST_F) m_lost = 1;
    endtask

    task automatic model_res(input int x, input int y, input int c);
        pos_t p;
        if (m_mode != 2) return;
        if (c >= MIN_C) begin
            p.x = 6'(x);
            p.y = 5'(y);
            // An unread position is replaced rather than queued behind.
            if (!POS_READY && exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                exp_ovr++;
            end
            exp_q.push_back(p);
            m_miss = 0;
            m_lost = 0;
        end else begin
            model_miss();
        end
    endtask

    task automatic model_fe(input bit coinc, input int x, input int y, input int c);
        if (m_mode != 0) m_frames = (m_frames + 1) % 65536;
        if (m_mode == 1) begin
            if (m_skip < SKIP_F) m_skip++;
            else m_mode = 2;
        end else if (m_mode == 2) begin
            if (coinc) model_res(x, y, c);
            else model_miss();
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic check_frame_state();
        @(negedge CLK);
        chk("lost", int'(LOST), m_lost);
        chk("frame_cnt", int'(FRAME_CNT), m_frames);
        chk("det_enable", int'(DET_ENABLE), (m_mode == 2) ? 1 : 0);
        if (POS_READY) begin
            chk("pos_valid_idle", int'(POS_VALID), 0);
            chk("queue_drained", exp_q.size(), 0);
        end
    endtask

    // kind 0: no result, 1: result mid-frame, 2: result coincident with fe
    task automatic frame(input int kind, input int x, input int y, input int c);
        repeat (2 + $urandom_range(0, 2)) tick();
        if (kind == 1) begin
            model_res(x, y, c);
            RES_X = 6'(x); RES_Y = 5'(y); RES_COUNT = 8'(c); RES_VALID = 1'b1;
            tick();
            RES_VALID = 1'b0;
            repeat (3) tick();
        end
        model_fe(kind == 2, x, y, c);
        VGA_VS = 1'b0;
        if (kind == 2) begin
            RES_X = 6'(x); RES_Y = 5'(y); RES_COUNT = 8'(c); RES_VALID = 1'b1;
        end
        tick();
        RES_VALID = 1'b0;
        tick();
        VGA_VS = 1'b1;
        repeat (4) tick();
        check_frame_state();
    endtask

    task automatic do_start();
        START = 1'b1;
        tick(); tick();
        m_mode = 1;
        m_skip = 0;
    endtask

    task automatic do_stop();
        START = 1'b0;
        tick(); tick();
        m_mode = 0; m_miss = 0; m_lost = 0;
        @(negedge CLK);
        chk("stop_det_enable", int'(DET_ENABLE), 0);
        chk("stop_lost", int'(LOST), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_det_enable"}, int'(DET_ENABLE), 0);
        chk({tag, "_pos_x"}, int'(POS_X), 0);
        chk({tag, "_pos_y"}, int'(POS_Y), 0);
        chk({tag, "_pos_valid"}, int'(POS_VALID), 0);
        chk({tag, "_lost"}, int'(LOST), 0);
        chk({tag, "_overrun"}, int'(OVERRUN), 0);
        chk({tag, "_frame_cnt"}, int'(FRAME_CNT), 0);
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; VGA_VS = 1'b1; RES_VALID = 1'b0;
        RES_X = '0; RES_Y = '0; RES_COUNT = '0; POS_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RST_N = 1'b1;
        tick();

        // Settling: first edge skipped, second enters detection.
        do_start();
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        chk("det_after_settle", int'(DET_ENABLE), 1);
        chk("frames_after_settle", int'(FRAME_CNT), 2);

        // Two-cycle latency from result pulse to POS_VALID.
        model_res(12, 7, 20);
        RES_X = 6'd12; RES_Y = 5'd7; RES_COUNT = 8'd20; RES_VALID = 1'b1;
        tick();
        RES_VALID = 1'b0;
        @(negedge CLK);
        chk("lat_cycle1_valid", int'(POS_VALID), 0);
        tick();
        @(negedge CLK);
        chk("lat_cycle2_valid", int'(POS_VALID), 1);
        chk("lat_pos_x", int'(POS_X), 12);
        chk("lat_pos_y", int'(POS_Y), 7);
        tick();
        @(negedge CLK);
        chk("lat_cycle3_valid", int'(POS_VALID), 0);

        // Four misses declare loss; one good frame recovers.
        frame(1, 1, 1, 3);
        frame(0, 0, 0, 0);
        frame(1, 2, 2, 3);
        frame(0, 0, 0, 0);
        chk("lost_after_4", int'(LOST), 1);
        frame(0, 0, 0, 0);
        frame(1, 9, 9, 9);
        chk("lost_recovered", int'(LOST), 0);

        // Coincident edge and result at exactly the threshold.
        frame(2, 3, 4, 8);

        // Overrun: consumer stalled, second hit replaces the first.
        POS_READY = 1'b0;
        frame(1, 5, 5, 20);
        frame(1, 6, 6, 20);
        @(negedge CLK);
        chk("ovr_pos_valid", int'(POS_VALID), 1);
        chk("ovr_pos_x", int'(POS_X), 6);

        // Stop during EVAL while a position is pending.
        RES_X = 6'd7; RES_Y = 5'd7; RES_COUNT = 8'd2; RES_VALID = 1'b1;
        tick();
        RES_VALID = 1'b0;
        START = 1'b0;
        tick();
        m_mode = 0; m_miss = 0; m_lost = 0;
        @(negedge CLK);
        chk("stop_eval_det", int'(DET_ENABLE), 0);
        chk("stop_eval_pos_valid", int'(POS_VALID), 1);
        chk("stop_eval_pos_x", int'(POS_X), 6);
        POS_READY = 1'b1;
        tick(); tick();
        @(negedge CLK);
        chk("stop_eval_drained", int'(POS_VALID), 0);
        chk("overrun_count", ovr_seen, exp_ovr);

        // Randomized tracking with occasional stop/restart.
        do_start();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                do_stop();
                do_start();
            end
            frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 39)),
                  int'($urandom_range(0, 29)), int'($urandom_range(0, 15)));
        end
        chk("overrun_count_final", ovr_seen, exp_ovr);

        // Asynchronous reset in the middle of a pending handshake.
        POS_READY = 1'b0;
        frame(1, 11, 11, 30);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        m_mode = 0; m_miss = 0; m_lost = 0; m_frames = 0;
        START = 1'b0;
        POS_READY = 1'b1;
        tick();
        RST_N = 1'b1;
        frame(0, 0, 0, 0);
        chk("post_reset_idle_det", int'(DET_ENABLE), 0);
        chk("post_reset_frame_cnt", int'(FRAME_CNT), 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
